// File: rtl/spi_ram_ctrl_if.sv
// Bus between the SPI receive/slave front end and spi_ram_ctrl.
// Carries received words plus the serial transmit handshake.
interface spi_ram_ctrl_if;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic       tx_en;
   logic       miso;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       cmd_err;

   modport master (
      output rx_data, rx_valid, tx_en,
      input  miso, tx_valid, tx_data, tx_done, cmd_err
   );

   modport slave (
      input  rx_data, rx_valid, tx_en,
      output miso, tx_valid, tx_data, tx_done, cmd_err
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command decoder, byte RAM and LSB-first read serializer.
// Ports: clk, rst (async active-low), bus (slave modport).
module spi_ram_ctrl #(
   parameter int ADDR_SIZE = 8
) (
   input  logic          clk,
   input  logic          rst,
   spi_ram_ctrl_if.slave bus
);
   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state, state_n;

   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, addr;
   logic [7:0] mem [0:(1<<ADDR_SIZE)-1];
   logic [7:0] tx_data, tx_data_n;
   logic [7:0] shift, shift_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic       miso, miso_n;
   logic       done, done_n;
   logic       err, err_n;
   logic [1:0] cmd;
   logic       rd_cmd;

   assign cmd    = bus.rx_data[9:8];
   assign addr   = bus.rx_data[ADDR_SIZE-1:0];
   assign rd_cmd = bus.rx_valid && (cmd == 2'b11);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr <= '0;
         rd_addr <= '0;
      end else if (bus.rx_valid) begin
         case (cmd)
            2'b00:   wr_addr <= addr;
            2'b10:   rd_addr <= addr;
            default: ;
         endcase
      end
   end

   // RAM is deliberately not reset.
   always_ff @(posedge clk) begin
      if (bus.rx_valid && (cmd == 2'b01))
         mem[wr_addr] <= bus.rx_data[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         tx_data <= '0;
         shift   <= '0;
         bit_cnt <= '0;
         miso    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         tx_data <= tx_data_n;
         shift   <= shift_n;
         bit_cnt <= bit_cnt_n;
         miso    <= miso_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      tx_data_n = tx_data;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      miso_n    = miso;
      done_n    = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            if (rd_cmd) begin
               tx_data_n = mem[rd_addr];
               shift_n   = mem[rd_addr];
               bit_cnt_n = '0;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            // Busy check uses the pre-edge state, so a read
            // on the last-bit edge is rejected.
            err_n = rd_cmd;
            if (bus.tx_en) begin
               miso_n  = shift[0];
               shift_n = shift >> 1;
               if (bit_cnt == 3'd7) begin
                  bit_cnt_n = '0;
                  done_n    = 1'b1;
                  state_n   = IDLE;
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.miso     = miso;
   assign bus.tx_valid = (state == SHIFT);
   assign bus.tx_data  = tx_data;
   assign bus.tx_done  = done;
   assign bus.cmd_err  = err;
endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Consumes the 10-bit words and one-cycle valid strobe produced by the SPI receive deserializer. Decodes each word as a 2-bit command plus an 8-bit payload. Owns the single-port RAM array and the write/read address registers. For read-data commands it loads the addressed byte and shifts it out LSB-first on miso under control of the upstream SPI slave FSM.

Parameters:
ADDR_SIZE, 8, address width; memory depth is 2**ADDR_SIZE bytes; legal range 1..8.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
rx_data  in  10  received word; [9:8] command, [7:0] payload
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_en  in  1  shift enable from SPI slave FSM, one bit per cycle while high
miso  out  1  serial read data, LSB first
tx_valid  out  1  read byte loaded and not yet fully shifted (busy)
tx_data  out  8  byte currently loaded for transmit
tx_done  out  1  one-cycle pulse on the edge the 8th bit is driven
cmd_err  out  1  one-cycle pulse when a read-data command is rejected

Behaviour:
- Reset (rst low, asynchronous): wr_addr=0, rd_addr=0, tx_data=0, shift reg=0, bit_cnt=0, miso=0, tx_valid=0, tx_done=0, cmd_err=0. Memory contents are not cleared; unwritten locations read X.
- Reset mid-shift aborts the transfer immediately. No tx_done is produced.
- Command decode happens only on a clock edge with rx_valid=1. The address field is rx_data[ADDR_SIZE-1:0]; upper payload bits are ignored when ADDR_SIZE<8.
- 2'b00, write address: wr_addr <= payload.
- 2'b01, write data: mem[wr_addr] <= rx_data[7:0]. wr_addr does not auto-increment.
- 2'b10, read address: rd_addr <= payload.
- 2'b11, read data, when tx_valid=0:
  - tx_data and the shift reg <= mem[rd_addr]; bit_cnt <= 0; tx_valid <= 1.
  - Registered read, so tx_valid and tx_data are visible the cycle after the rx_valid edge.
- 2'b11, read data, when tx_valid=1: the command is ignored. cmd_err=1 for exactly one cycle. The transfer in progress continues undisturbed.
- Commands 00/01/10 are always accepted, including during a shift.
- Write-then-read ordering: a 01 on edge N followed by 11 on edge N+1 for the same address returns the new byte.
- Serializer states: IDLE (tx_valid=0) and SHIFT (tx_valid=1).
  - In SHIFT with tx_en=1, each edge: miso <= shift[0]; shift >>= 1; bit_cnt++.
  - In SHIFT with tx_en=0: shift reg, bit_cnt and miso hold.
  - On the edge that drives bit 7 (bit_cnt==7): tx_valid <= 0, bit_cnt <= 0, tx_done <= 1 for one cycle. Return to IDLE.
  - A new 11 command is accepted on that same edge only if tx_valid was 0 before it. It is therefore rejected on the final-bit edge and accepted from the next edge.
- miso holds its last driven value in IDLE.
- tx_en while IDLE has no effect.
- tx_data holds the last loaded byte until the next accepted read-data command or reset.

Test Plan:
- Reset, then 0x0_25 (wr addr 0x25), then 0x1_A7 (wr data) -> mem[0x25]=0xA7; no tx_valid, no cmd_err.
- Continue with 0x2_25 and 0x3_00, tx_en held high -> tx_valid=1 one cycle after the strobe, tx_data=0xA7. miso sequence over the following 8 cycles is 1,1,1,0,0,1,0,1. tx_done pulses on the 8th bit; tx_valid=0 afterwards.
- Same read with tx_en toggling 1,0,1,0... -> the bit sequence is unchanged and completion takes 16 cycles. miso is stable during the low cycles.
- Issue 0x3_xx while the previous byte is at bit 3 -> cmd_err pulses one cycle; the remaining bits are unaltered; no reload.
- Issue 0x1_5C to the current wr_addr mid-shift -> the write lands in memory, the shifting byte is unaffected, and a subsequent read returns 0x5C.
- Assert rst low mid-shift at bit 4 -> miso, tx_valid and tx_done go 0 immediately. wr_addr=rd_addr=0 afterwards. Memory still holds previously written bytes.
